fetch_unit: RTL

Instruction fetch front-end for the RISC-V core. It owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel, and matches in-order responses to their PCs in a reserve-then-fill queue. It presents `{pc, pc_p_4, instr}` to the datapath with a valid/ready handshake, and flushes on a taken branch or jump (`redirect`, driven from `pc_src`/`pc_ext`).

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 74 +++++++
 rtl/fetch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Reserve-then-fill queue: entries are allocated at request time, filled by in-order responses, popped at the head.
// Latency: fill to head_vld is 1 cycle (registered entry); pop takes effect at the next edge.
// Backpressure: never refuses; the owner limits alloc so count never exceeds DEPTH.
//
// Ports: clk, rst (sync, active-high), flush (drops every entry), alloc_vld/alloc_pc (reserve),
//        fill_vld/fill_dat (complete the oldest unfilled entry), pop_vld (consume head, gated by head_vld),
//        head_vld/head_pc/head_dat (head entry), count (allocated), unfilled (allocated, awaiting data).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          alloc_vld,
  input  logic [31:0]   alloc_pc,
  input  logic          fill_vld,
  input  logic [31:0]   fill_dat,
  input  logic          pop_vld,
  output logic          head_vld,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_dat,
  output logic [CW-1:0] count,
  output logic [CW-1:0] unfilled
);

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;
  logic          pop;
  fetch_entry_t  entries [DEPTH];

  assign head_vld = (count != '0) && entries[head_ptr].filled;
  assign head_pc  = entries[head_ptr].pc;
  assign head_dat = entries[head_ptr].data;
  assign pop      = pop_vld && head_vld;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      unfilled  <= '0;
    end else begin
      if (alloc_vld) alloc_ptr <= alloc_ptr + PW'(1);
      if (fill_vld)  fill_ptr  <= fill_ptr + PW'(1);
      if (pop)       head_ptr  <= head_ptr + PW'(1);
      count    <= count + CW'(alloc_vld) - CW'(pop);
      unfilled <= unfilled + CW'(alloc_vld) - CW'(fill_vld);
    end
  end

  // Entry payload needs no reset: allocation clears 'filled' before the
  // entry can be seen, and head_vld is qualified by count. Alloc and fill
  // never target the same slot: that would need unfilled==0 (no legal fill)
  // or a full queue of unfilled entries (no alloc possible).
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (alloc_vld) begin
        entries[alloc_ptr].pc     <= alloc_pc;
        entries[alloc_ptr].filled <= 1'b0;
      end
      if (fill_vld) begin
        entries[fill_ptr].data   <= fill_dat;
        entries[fill_ptr].filled <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns fetch_pc, issues word requests, pairs in-order responses with PCs, flushes on redirect.
// Latency: response edge to instr_valid 1 cycle; redirect at N gives a request to the new target at N+1.
// Backpressure: instr_ready low fills the queue, then imem_req_valid drops; imem_req_ready low holds the request stable.
//
// Ports: clk, rst (sync, active-high); imem_req_valid/ready/addr (request channel);
//        imem_rsp_valid/data (in-order responses, no backpressure); redirect/redirect_pc (flush + new target);
//        instr_valid/ready with instr, pc, pc_p_4 (head of queue; NOP/0/0 when not valid).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_p_4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [CW-1:0] q_unfilled;
  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          rsp_fill;
  logic          rsp_drop;
  logic [31:0]   head_pc;
  logic [31:0]   head_dat;

  // Slots still owed a response (live entries plus responses to discard)
  // bound the number of requests in flight.
  assign occupancy      = {1'b0, q_count} + {1'b0, drop_cnt};
  assign imem_req_valid = !rst && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response in the redirect cycle belongs to pre-redirect traffic, so it
  // is always discarded, even if it would otherwise have filled an entry.
  assign rsp_drop = imem_rsp_valid && (redirect || (drop_cnt != '0));
  assign rsp_fill = imem_rsp_valid && !redirect && (drop_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      drop_cnt <= drop_cnt + q_unfilled - CW'(rsp_drop);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .alloc_vld (req_fire),
    .alloc_pc  (fetch_pc),
    .fill_vld  (rsp_fill),
    .fill_dat  (imem_rsp_data),
    .pop_vld   (instr_ready),
    .head_vld  (instr_valid),
    .head_pc   (head_pc),
    .head_dat  (head_dat),
    .count     (q_count),
    .unfilled  (q_unfilled)
  );

  assign instr  = instr_valid ? head_dat : NOP_INSTR;
  assign pc     = instr_valid ? head_pc : 32'd0;
  assign pc_p_4 = instr_valid ? (head_pc + 32'd4) : 32'd0;

  // Every response must have a request waiting for it.
  rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((drop_cnt != '0) || (q_unfilled != '0)));

endmodule
